// File: rtl/inst_loader_if.sv
// Operator/memory-side bundle for the instruction loader.
//   master : operator/memory side (drives switches, button, lane select; sees LEDs and write port)
//   slave  : the loader itself
// Signals: Button, Data_in[7:0], Select[1:0] toward the loader;
//          LED[7:0], Mem_we, Mem_addr[ADDR_W-1:0], Mem_din[31:0], Byte_cnt[1:0], Full back.
interface inst_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              Button;
  logic [7:0]        Data_in;
  logic [1:0]        Select;
  logic [7:0]        LED;
  logic              Mem_we;
  logic [ADDR_W-1:0] Mem_addr;
  logic [31:0]       Mem_din;
  logic [1:0]        Byte_cnt;
  logic              Full;

  modport master (
    output Button, Data_in, Select,
    input  LED, Mem_we, Mem_addr, Mem_din, Byte_cnt, Full
  );

  modport slave (
    input  Button, Data_in, Select,
    output LED, Mem_we, Mem_addr, Mem_din, Byte_cnt, Full
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: assembles 32-bit words from bytes entered on switches,
// one debounced button press per byte (little-endian), and writes each
// completed word to instruction memory at a self-incrementing word address.
// Ports:
//   Clk      - system clock, all state on posedge
//   Rst      - asynchronous active-high reset
//   bus      - inst_loader_if.slave: Button, Data_in, Select in;
//              LED (selected byte lane, combinational), Mem_we, Mem_addr,
//              Mem_din, Byte_cnt, Full out
// Build option: INST_LOADER_WRAP_EN - address wraps to 0 after the last
//   word instead of locking in FULL; Full is then tied low.
module inst_loader #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DEBOUNCE_LEN = 3
) (
  input  logic           Clk,
  input  logic           Rst,
  inst_loader_if.slave   bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic [WORD_W-1:0]       word_q,     word_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]       addr_q,     addr_d;

  logic                    sync1_q,    sync1_d;
  logic                    sync2_q,    sync2_d;
  logic [DEBOUNCE_LEN-1:0] shift_q,    shift_d;
  logic                    pressed_q,  pressed_d;

  logic                    level;
  logic                    strobe;

  // Button conditioning: 2-flop synchronizer, then a run-length shift register
  always_comb begin
    sync1_d   = bus.Button;
    sync2_d   = sync1_q;
    shift_d   = (shift_q << 1) | DEBOUNCE_LEN'(sync2_q);
    level     = &shift_q;
    pressed_d = level;
    strobe    = level & ~pressed_q;
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;

    case (state_q)
      COLLECT: begin
        if (strobe) begin
          word_d[{byte_cnt_q, 3'b000} +: BYTE_W] = bus.Data_in;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      // Single write cycle; presses landing here are intentionally dropped
      WRITE: begin
        word_d = '0;
        if (addr_q == {ADDR_W{1'b1}}) begin
`ifdef INST_LOADER_WRAP_EN
          addr_d  = '0;
          state_d = COLLECT;
`else
          state_d = FULL;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = COLLECT;
        end
      end

      FULL: begin
        state_d = FULL;
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= COLLECT;
      word_q     <= '0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= '0;
      pressed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      shift_q    <= shift_d;
      pressed_q  <= pressed_d;
    end
  end

  // Outputs are decoded straight from registers
  assign bus.LED      = word_q[{bus.Select, 3'b000} +: BYTE_W];
  assign bus.Mem_we   = (state_q == WRITE);
  assign bus.Mem_addr = addr_q;
  assign bus.Mem_din  = word_q;
  assign bus.Byte_cnt = byte_cnt_q;
`ifdef INST_LOADER_WRAP_EN
  assign bus.Full     = 1'b0;
`else
  assign bus.Full     = (state_q == FULL);
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (ADDR_W=2, DEBOUNCE_LEN=3): reset behaviour,
// bouncy press, table of word commits with lane/LED checks, fill or wrap.
module tb_inst_loader;

  localparam int unsigned ADDR_W = 2;

  logic Clk;
  logic Rst;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(
    .ADDR_W      (ADDR_W),
    .DEBOUNCE_LEN(3)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: logs every write and checks each strobe lasts one cycle
  int                wr_cnt = 0;
  int                we_run = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       last_din;

  always @(negedge Clk) begin
    if (Rst) begin
      we_run = 0;
    end else if (bus.Mem_we === 1'b1) begin
      wr_cnt++;
      we_run++;
      last_addr = bus.Mem_addr;
      last_din  = bus.Mem_din;
    end else if (we_run != 0) begin
      check("we_pulse_width", 32'(we_run), 32'd1);
      we_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Clean press; Data_in is scrambled after the capture edge to prove it is ignored
  task automatic press(input logic [7:0] d);
    bus.Data_in = d;
    bus.Button  = 1'b1;
    tick(7);
    bus.Data_in = ~d;
    tick(2);
    bus.Button  = 1'b0;
    tick(8);
  endtask

  task automatic pulse_reset();
    #2 Rst = 1'b1;
    #3 Rst = 1'b0;
    tick(1);
  endtask

  task automatic check_led(input string name, input logic [1:0] sel, input logic [7:0] exp);
    bus.Select = sel;
    #1;
    check(name, 32'(bus.LED), 32'(exp));
  endtask

  typedef struct {
    logic [31:0]       bytes;     // byte k is entered k-th
    logic [ADDR_W-1:0] addr;      // write address expected
    logic [31:0]       din;       // written word expected
    logic [ADDR_W-1:0] next_addr; // Mem_addr after commit
    logic              full;      // Full after commit
  } vec_t;

`ifdef INST_LOADER_WRAP_EN
  localparam int N_WORDS = 5;
`else
  localparam int N_WORDS = 4;
`endif

  vec_t vecs[N_WORDS];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr_before;
    logic [7:0] b;

    vecs[0] = '{32'h0000_0013, 2'd0, 32'h0000_0013, 2'd1, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF, 2'd2, 1'b0};
    vecs[2] = '{32'h0403_0201, 2'd2, 32'h0403_0201, 2'd3, 1'b0};
`ifdef INST_LOADER_WRAP_EN
    vecs[3] = '{32'h007F_80FF, 2'd3, 32'h007F_80FF, 2'd0, 1'b0};
    vecs[4] = '{32'h8877_6655, 2'd0, 32'h8877_6655, 2'd1, 1'b0};
`else
    vecs[3] = '{32'h007F_80FF, 2'd3, 32'h007F_80FF, 2'd3, 1'b1};
`endif

    Rst         = 1'b1;
    bus.Button  = 1'b0;
    bus.Data_in = 8'h00;
    bus.Select  = 2'd0;
    tick(3);
    Rst = 1'b0;
    tick(2);

    // Reset state
    check("rst_byte_cnt", 32'(bus.Byte_cnt), 32'd0);
    check("rst_addr",     32'(bus.Mem_addr), 32'd0);
    check("rst_we",       32'(bus.Mem_we),   32'd0);
    check("rst_full",     32'(bus.Full),     32'd0);
    check("rst_din",      bus.Mem_din,       32'd0);
    check_led("rst_led",  2'd0, 8'h00);

    // Reset mid-word
    press(8'h11);
    press(8'h22);
    check("mid_byte_cnt", 32'(bus.Byte_cnt), 32'd2);
    check_led("mid_led1", 2'd1, 8'h22);
    pulse_reset();
    check("midrst_byte_cnt", 32'(bus.Byte_cnt), 32'd0);
    check("midrst_addr",     32'(bus.Mem_addr), 32'd0);
    check("midrst_wr_cnt",   32'(wr_cnt),       32'd0);
    for (int s = 0; s < 4; s++) check_led("midrst_led", 2'(s), 8'h00);

    // Bouncy press: 1,0,1,0 then held for 10 cycles -> one byte
    bus.Data_in = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      bus.Button = (i % 2 == 0);
      tick(1);
    end
    bus.Button = 1'b1;
    tick(10);
    bus.Button = 1'b0;
    tick(8);
    check("bounce_byte_cnt", 32'(bus.Byte_cnt), 32'd1);
    check_led("bounce_led0", 2'd0, 8'hA5);
    check("bounce_wr_cnt", 32'(wr_cnt), 32'd0);
    pulse_reset();

    // Word commits from the table
    for (int w = 0; w < N_WORDS; w++) begin
      wr_before = wr_cnt;
      for (int k = 0; k < 3; k++) begin
        b = vecs[w].bytes[8*k +: 8];
        press(b);
      end
      check("pre_byte_cnt", 32'(bus.Byte_cnt), 32'd3);
      for (int s = 0; s < 4; s++) begin
        b = (s < 3) ? vecs[w].bytes[8*s +: 8] : 8'h00;
        check_led("pre_led", 2'(s), b);
      end
      check("pre_no_write", 32'(wr_cnt), 32'(wr_before));
      b = vecs[w].bytes[31:24];
      press(b);
      check("commit_count",   32'(wr_cnt),       32'(wr_before + 1));
      check("commit_addr",    32'(last_addr),    32'(vecs[w].addr));
      check("commit_din",     last_din,          vecs[w].din);
      check("post_addr",      32'(bus.Mem_addr), 32'(vecs[w].next_addr));
      check("post_byte_cnt",  32'(bus.Byte_cnt), 32'd0);
      check("post_full",      32'(bus.Full),     32'(vecs[w].full));
      check("post_din_clear", bus.Mem_din,       32'd0);
      check_led("post_led0",  2'd0, 8'h00);
    end

`ifndef INST_LOADER_WRAP_EN
    // Locked: a further press is ignored
    wr_before = wr_cnt;
    press(8'h5A);
    check("full_no_write", 32'(wr_cnt),       32'(wr_before));
    check("full_byte_cnt", 32'(bus.Byte_cnt), 32'd0);
    check("full_sticky",   32'(bus.Full),     32'd1);
    check_led("full_led0", 2'd0, 8'h00);
    pulse_reset();
    check("full_rst_full", 32'(bus.Full),     32'd0);
    check("full_rst_addr", 32'(bus.Mem_addr), 32'd0);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
